imem_fetch_port: RTL

Parametrised, handshaked instruction memory serving the fetch stage. It accepts one fetch request per cycle over a valid/ready interface and reads a little-endian 32-bit word after a configurable pipeline latency. Each response is buffered so the decode stage can apply back-pressure without losing data, and misaligned or out-of-range fetches are flagged. A byte-enabled loader port preloads the program, and a flush input discards in-flight fetches on redirect.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_fetch_port_if.sv | 28 ++
 rtl/imem_rsp_fifo.sv | 69 ++++++
 rtl/imem_fetch_port.sv | 111 +++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch port.
package imem_pkg;

  localparam logic [1:0]  FAULT_NONE     = 2'b00;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
  localparam logic [1:0]  FAULT_RANGE    = 2'b10;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
    logic [1:0]  code;
  } imem_rsp_t;

  // Misalignment is checked first so it masks an out-of-range report.
  function automatic logic [1:0] fault_code(logic [31:0] addr, int unsigned depth_bytes);
    if (addr[1:0] != 2'b00) begin
      return FAULT_MISALIGN;
    end else if (addr > depth_bytes - 4) begin
      return FAULT_RANGE;
    end
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/imem_fetch_port_if.sv
// Request, response, loader and flush signals of the fetch port.
interface imem_fetch_port_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_fault;
  logic [1:0]  rsp_fault_code;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  ld_be;
  logic        flush;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data, ld_be, flush,
    input  req_ready, rsp_valid, rsp_instr, rsp_fault, rsp_fault_code
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data, ld_be, flush,
    output req_ready, rsp_valid, rsp_instr, rsp_fault, rsp_fault_code
  );

endinterface

// File: rtl/imem_rsp_fifo.sv
// Response buffer between the read pipeline and the decode consumer.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  imem_rsp_t                  data_i,
  input  logic                       pop_i,
  output imem_rsp_t                  head_o,
  output logic                       valid_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  imem_rsp_t       mem_q [Depth];
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push_en, pop_en;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign pop_en  = pop_i && (cnt_q != '0);
  assign push_en = push_i && ((cnt_q < CntW'(Depth)) || pop_en);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_en) wr_d = ptr_inc(wr_q);
      if (pop_en)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CntW'(push_en) - CntW'(pop_en);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/imem_fetch_port.sv
// Handshaked instruction memory: byte-enabled loader, fault check, fixed-latency
// read pipeline and a response FIFO sized to cover every outstanding fetch.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned RSP_DEPTH   = LATENCY + 1
) (
  input logic              clk,
  input logic              rst_n,
  imem_fetch_port_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  logic [7:0]      mem [DEPTH_BYTES];
  logic [AW-3:0]   ld_widx, rd_widx;
  logic [1:0]      req_code;
  imem_rsp_t       req_rsp;

  logic [LATENCY-1:0]            pv_q, pv_d;
  imem_rsp_t [LATENCY-1:0]       pd_q, pd_d;
  logic                          accept, pop;
  logic [CW-1:0]                 inflight, fifo_count;
  logic                          fifo_valid;
  imem_rsp_t                     fifo_head;
  logic                          unused_ld_addr;

  assign ld_widx        = bus.ld_addr[AW-1:2];
  assign rd_widx        = bus.req_addr[AW-1:2];
  assign unused_ld_addr = ^{bus.ld_addr[31:AW], bus.ld_addr[1:0]};

  // Program store is deliberately not reset so a reset keeps the loaded image.
  always_ff @(posedge clk) begin
    if (bus.ld_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.ld_be[b]) mem[{ld_widx, b[1:0]}] <= bus.ld_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    req_code      = fault_code(bus.req_addr, DEPTH_BYTES);
    req_rsp.code  = req_code;
    req_rsp.fault = (req_code != FAULT_NONE);
    if (req_rsp.fault) begin
      req_rsp.instr = NOP_INSTR;
    end else begin
      req_rsp.instr = {mem[{rd_widx, 2'd3}], mem[{rd_widx, 2'd2}],
                       mem[{rd_widx, 2'd1}], mem[{rd_widx, 2'd0}]};
    end
  end

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      inflight = inflight + CW'(pv_q[i]);
    end
  end

  // Occupancy counts only registered state, so rsp_ready never reaches req_ready.
  assign bus.req_ready = !bus.flush && !bus.ld_en &&
                         ((inflight + fifo_count) < CW'(RSP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = fifo_valid && bus.rsp_ready && !bus.flush;

  always_comb begin
    pv_d    = '0;
    pd_d    = pd_q;
    pd_d[0] = req_rsp;
    if (!bus.flush) begin
      pv_d[0] = accept;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pv_d[i] = pv_q[i-1];
        pd_d[i] = pd_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      pd_q <= '0;
    end else begin
      pv_q <= pv_d;
      pd_q <= pd_d;
    end
  end

  imem_rsp_fifo #(
    .Depth (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (bus.flush),
    .push_i  (pv_q[LATENCY-1]),
    .data_i  (pd_q[LATENCY-1]),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign bus.rsp_valid      = fifo_valid;
  assign bus.rsp_instr      = fifo_valid ? fifo_head.instr : '0;
  assign bus.rsp_fault      = fifo_valid ? fifo_head.fault : 1'b0;
  assign bus.rsp_fault_code = fifo_valid ? fifo_head.code  : FAULT_NONE;

endmodule
